// File: rtl/img_mem_reader.sv
// img_mem_reader
// Streams a contiguous block of words from a synchronous-read memory
// (one cycle read latency) out over a valid/ready source port.
// A small FIFO absorbs downstream backpressure, and reads are throttled
// so that buffered words plus reads in flight never exceed FIFO_DEPTH.
//
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   start               : one-cycle request, honoured only while idle
//   base_addr, length   : transfer window, sampled when start is accepted
//   busy / done / error : status; done and error are one-cycle pulses
//   mem_*               : memory read port (write side tied off)
//   src_*               : streamed pixel output with sop/eop framing
module img_mem_reader #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int MEM_WORDS  = 81920,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_W + 1;
    localparam int SUM_W = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   issued_cnt;
    logic [LEN_W-1:0]   out_idx;
    logic               done_r;

    // Read issued last cycle: its data is on mem_readdata this cycle.
    logic               rd_vld_p1;

    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic [SUM_W-1:0]   end_addr;
    logic               start_ok;
    logic               pop;
    logic               last_pop;
    logic               room;
    logic               issue;

    // Wide sum so base_addr+length cannot overflow before the range test.
    assign end_addr = SUM_W'(base_addr) + SUM_W'(length);
    assign start_ok = (end_addr <= SUM_W'(MEM_WORDS));

    assign src_valid = (fifo_count != '0);
    assign src_data  = src_valid ? fifo_mem[rd_ptr] : '0;
    assign src_sop   = src_valid && (out_idx == '0);
    assign src_eop   = src_valid && (out_idx == (len_r - LEN_W'(1)));
    assign pop       = src_valid && src_ready;
    assign last_pop  = pop && src_eop && (state == DRAIN);

    // Reads in flight are the one strobed this cycle and the one whose
    // data lands this cycle; counting both keeps the FIFO from overflowing.
    assign room  = (fifo_count + CNT_W'(mem_chipselect) + CNT_W'(rd_vld_p1))
                   < CNT_W'(FIFO_DEPTH);
    assign issue = (state == FETCH) && room && (issued_cnt < len_r);

    // Completion is signalled in the same cycle the final word is taken.
    assign done = done_r | last_pop;

    assign mem_clken     = 1'b1;
    assign mem_write     = 1'b0;
    assign mem_writedata = '0;

    // Control FSM and read-address generation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done_r         <= 1'b0;
            error          <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            base_r         <= '0;
            len_r          <= '0;
            issued_cnt     <= '0;
        end else begin
            done_r         <= 1'b0;
            error          <= 1'b0;
            mem_chipselect <= issue;
            if (issue) begin
                mem_address <= base_r + issued_cnt[ADDR_W-1:0];
                issued_cnt  <= issued_cnt + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!start_ok) begin
                            error <= 1'b1;
                        end else if (length == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            base_r     <= base_addr;
                            len_r      <= length;
                            issued_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue && ((issued_cnt + LEN_W'(1)) == len_r)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return stage and FIFO bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_p1  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_idx    <= '0;
        end else begin
            rd_vld_p1 <= mem_chipselect;
            if (rd_vld_p1) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                out_idx <= out_idx + LEN_W'(1);
            end
            if (state == IDLE) begin
                out_idx <= '0;
            end
            fifo_count <= fifo_count + CNT_W'(rd_vld_p1) - CNT_W'(pop);
        end
    end

    // FIFO storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (rd_vld_p1) begin
            fifo_mem[wr_ptr] <= mem_readdata;
        end
    end

endmodule
